// File: rtl/dpram_ctrl_pkg.sv
// Shared types and defaults for the dual-port RAM port arbiter.
// Build option: DPRAM_ARB_INIT_EN enables the post-reset memory clear sweep.
package dpram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 8;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Travels alongside a read while the RAM access is in flight.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid request at or after the
// priority pointer and moves the pointer one past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_advance,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;

  // Scan the requests starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_idx           = w_cand;
      end
    end
  end

  // Pointer value after a grant to w_idx.
  always_comb begin
    w_ptr_next = w_idx + IDX_W'(1);
    if (w_idx == IDX_W'(NUM_REQ-1)) begin
      w_ptr_next = '0;
    end
  end

  // The pointer only moves when something was actually granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM port among NUM_REQ requesters (round-robin),
// issues accepted requests in order and returns tagged read data.
// Build option: DPRAM_ARB_INIT_EN adds an INIT sweep writing INIT_VALUE
// to every location after reset before any request is accepted.
module dpram_port_arbiter
  import dpram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INIT_VALUE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         init_done,
  output logic                         mem_en_n,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  input  logic [DATA_WIDTH-1:0]        mem_dout
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_run;
  logic                  w_init_wr;
  logic                  w_init_last;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic [NUM_REQ-1:0]    w_req_masked;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_gnt_idx;
  logic                  w_accept;
  logic                  w_gnt_we;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_wdata;
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  logic                  r_mem_en_n;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  rd_tag_t               r_tag1;
  rd_tag_t               r_tag2;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;

`ifdef DPRAM_ARB_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;

  // Extra MSB flags that the whole depth has been written.
  logic [ADDR_WIDTH:0] r_init_cnt;

  assign w_init_last = r_init_cnt[ADDR_WIDTH];
  assign w_init_wr   = (r_state == ST_INIT) && !w_init_last;
  assign w_init_addr = r_init_cnt[ADDR_WIDTH-1:0];
  assign init_done   = (r_state == ST_RUN);

  // Sweep address counter, restarted by every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
    end else if (w_init_wr) begin
      r_init_cnt <= r_init_cnt + (ADDR_WIDTH+1)'(1);
    end
  end
`else
  localparam state_e RESET_STATE = ST_RUN;

  assign w_init_last = 1'b1;
  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
  assign init_done   = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leave INIT one cycle after the final sweep write is driven.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Grants are suppressed during INIT and while reset is held.
  assign w_run        = rst_n && (r_state == ST_RUN);
  assign w_req_masked = req_valid & {NUM_REQ{w_run}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (w_req_masked),
    .i_advance   (w_run),
    .o_grant     (w_grant),
    .o_grant_idx (w_gnt_idx)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_gnt_we    = req_we[w_gnt_idx];
  assign w_gnt_addr  = w_addr_arr[w_gnt_idx];
  assign w_gnt_wdata = w_wdata_arr[w_gnt_idx];

  // Issue stage: register the RAM pins; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en_n <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else if (w_init_wr) begin
      r_mem_en_n <= 1'b0;
      r_mem_we   <= 1'b1;
      r_mem_addr <= w_init_addr;
      r_mem_din  <= DATA_WIDTH'(INIT_VALUE);
    end else if (w_accept) begin
      r_mem_en_n <= 1'b0;
      r_mem_we   <= w_gnt_we;
      r_mem_addr <= w_gnt_addr;
      r_mem_din  <= w_gnt_wdata;
    end else begin
      r_mem_en_n <= 1'b1;
      r_mem_we   <= 1'b0;
    end
  end

  // Read tag pipeline: stage 1 aligns with the RAM pins, stage 2 with mem_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1.valid <= w_accept && !w_gnt_we;
      r_tag1.id    <= TAG_ID_W'(w_gnt_idx);
      r_tag2       <= r_tag1;
    end
  end

  // Response register: capture RAM read data while its tag is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_tag2.valid;
      if (r_tag2.valid) begin
        r_rsp_id   <= r_tag2.id[ID_W-1:0];
        r_rsp_data <= mem_dout;
      end
    end
  end

  assign mem_en_n  = r_mem_en_n;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM on the memory pins, a
// reference memory plus response scoreboard, table-driven arbitration
// vectors and hand-written timing sequences. Adapts to DPRAM_ARB_INIT_EN.
`timescale 1ns/1ps
module tb_dpram_port_arbiter;

  localparam int NR       = 4;
  localparam int AW       = 5;
  localparam int DW       = 8;
  localparam int DEPTH    = 32;
  localparam int INIT_VAL = 0;
`ifdef DPRAM_ARB_INIT_EN
  localparam logic EXP_INIT_DONE_RST = 1'b0;
`else
  localparam logic EXP_INIT_DONE_RST = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            init_done;
  logic            mem_en_n;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_en_n(mem_en_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37 + 11);
  endfunction

  // Behavioural synchronous RAM port, preloaded with a known pattern.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      foreach (ram[i]) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (!mem_en_n) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout      <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected read results in acceptance order.
  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  exp_t          sb_q[$];
  exp_t          sb_e;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_loaded = 1'b0;

  // Reference model: track accepted requests in order.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
`ifdef DPRAM_ARB_INIT_EN
      foreach (ref_mem[i]) ref_mem[i] <= DW'(INIT_VAL);
`else
      if (!ref_loaded) foreach (ref_mem[i]) ref_mem[i] <= pat(i);
`endif
      ref_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_we[i]) begin
            ref_mem[req_addr[i*AW +: AW]] <= req_wdata[i*DW +: DW];
            $display("ACCEPT write id=%0d addr=0x%0h data=0x%0h", i, req_addr[i*AW +: AW], req_wdata[i*DW +: DW]);
          end else begin
            sb_q.push_back('{i, ref_mem[req_addr[i*AW +: AW]]});
            $display("ACCEPT read  id=%0d addr=0x%0h", i, req_addr[i*AW +: AW]);
          end
        end
      end
    end
  end

  // Response checker.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        $display("RESP id=%0d data=0x%0h expected id=%0d data=0x%0h", rsp_id, rsp_data, sb_e.id, sb_e.data);
        check("rsp_id", 32'(rsp_id), 32'(sb_e.id));
        check("rsp_data", 32'(rsp_data), 32'(sb_e.data));
      end
    end
  end

  task automatic clr_req();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_en_n"}, 32'(mem_en_n), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'(EXP_INIT_DONE_RST));
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Arbitration vectors; packed lanes are {req3, req2, req1, req0}.
  typedef struct {
    logic [NR-1:0]         valid;
    logic [NR-1:0]         we;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][DW-1:0] wdata;
    logic [NR-1:0]         exp_ready;
  } vec_t;
  vec_t vecs [12];

  logic [DW-1:0] exp_rd;
  int            rsp_cnt;
  int            wait_cyc;

  initial begin
    vecs[0]  = '{4'b0110, 4'b0010, {5'd0, 5'd3, 5'd3, 5'd0},       {8'h00, 8'h00, 8'h11, 8'h00}, 4'b0010};
    vecs[1]  = '{4'b0100, 4'b0000, {5'd0, 5'd3, 5'd0, 5'd0},       {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0100};
    vecs[2]  = '{4'b1001, 4'b0001, {5'd4, 5'd0, 5'd0, 5'd4},       {8'h00, 8'h00, 8'h00, 8'h33}, 4'b1000};
    vecs[3]  = '{4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4},       {8'h00, 8'h00, 8'h00, 8'h33}, 4'b0001};
    vecs[4]  = '{4'b0000, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},       {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000};
    vecs[5]  = '{4'b1111, 4'b0000, {5'd4, 5'd4, 5'd4, 5'd4},       {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0010};
    vecs[6]  = '{4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd4},       {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0001};
    vecs[7]  = '{4'b1100, 4'b0100, {5'h1F, 5'h1F, 5'd0, 5'd0},     {8'h00, 8'hAB, 8'h00, 8'h00}, 4'b0100};
    vecs[8]  = '{4'b1000, 4'b0000, {5'h1F, 5'd0, 5'd0, 5'd0},      {8'h00, 8'h00, 8'h00, 8'h00}, 4'b1000};
    vecs[9]  = '{4'b1010, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd0},       {8'h5A, 8'h00, 8'h00, 8'h00}, 4'b0010};
    vecs[10] = '{4'b1000, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd0},       {8'h5A, 8'h00, 8'h00, 8'h00}, 4'b1000};
    vecs[11] = '{4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},       {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0001};

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

`ifdef DPRAM_ARB_INIT_EN
    // Init sweep: one write per cycle on 0..DEPTH-1, init_done in cycle DEPTH+1.
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      check("init_sweep", {19'd0, mem_en_n, mem_we, init_done, AW'(mem_addr), mem_din},
            {19'd0, 1'b0, 1'b1, 1'b0, AW'(c), DW'(INIT_VAL)});
    end
`endif
    @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);

    // All requesters valid for 8 cycles: grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(8 + i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      @(negedge clk);
      if (k == 7) clr_req();
      check("burst_en_n", 32'(mem_en_n), 32'd0);
      check("burst_addr", 32'(mem_addr), 32'(8 + (k % 4)));
    end
    @(negedge clk);
    check("idle_en_n", 32'(mem_en_n), 32'd1);
    check("idle_we", 32'(mem_we), 32'd0);
    check("idle_addr_hold", 32'(mem_addr), 32'd11);
    repeat (4) @(negedge clk);

    // Read address 7 after reset/init.
`ifdef DPRAM_ARB_INIT_EN
    exp_rd = 8'h00;
`else
    exp_rd = pat(7);
`endif
    set_req(0, 1'b0, 5'd7, 8'h00);
    #1 check("rd7_ready", 32'(req_ready), 32'b0001);
    @(negedge clk); clr_req();
    check("rd7_t1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd7_t2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd7_t3_valid", 32'(rsp_valid), 32'd1);
    check("rd7_data", 32'(rsp_data), 32'(exp_rd));
    repeat (2) @(negedge clk);

    // Write 0xF0 to 0x15 then read it back on the next cycle.
    set_req(0, 1'b1, 5'h15, 8'hF0);
    #1 check("wr15_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("wr15_pins", {mem_en_n, mem_we, AW'(mem_addr), mem_din}, {1'b0, 1'b1, 5'h15, 8'hF0});
    set_req(0, 1'b0, 5'h15, 8'h00);
    #1 check("rd15_ready", 32'(req_ready), 32'b0001);
    @(negedge clk); clr_req();
    check("rd15_pins", {mem_en_n, mem_we, AW'(mem_addr)}, {1'b0, 1'b0, 5'h15});
    check("rd15_t1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd15_t2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd15_t3_valid", 32'(rsp_valid), 32'd1);
    check("rd15_id", 32'(rsp_id), 32'd0);
    check("rd15_data", 32'(rsp_data), 32'hF0);
    repeat (2) @(negedge clk);

    // Req2 reads 0x18 while req3 writes 0xF8 to 0x0A: req2 first.
    exp_rd = ref_mem[5'h18];
    set_req(2, 1'b0, 5'h18, 8'h00);
    set_req(3, 1'b1, 5'h0A, 8'hF8);
    #1 check("pair_ready_first", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("pair_rd_pins", {mem_en_n, mem_we, AW'(mem_addr)}, {1'b0, 1'b0, 5'h18});
    #1 check("pair_ready_second", 32'(req_ready), 32'b1000);
    @(negedge clk); clr_req();
    check("pair_wr_pins", {mem_en_n, mem_we, AW'(mem_addr), mem_din}, {1'b0, 1'b1, 5'h0A, 8'hF8});
    @(negedge clk);
    check("pair_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pair_rsp_id", 32'(rsp_id), 32'd2);
    check("pair_rsp_data", 32'(rsp_data), 32'(exp_rd));
    repeat (2) @(negedge clk);

    // Table-driven arbitration, one vector per cycle.
    for (int n = 0; n < 12; n++) begin
      req_valid = vecs[n].valid;
      req_we    = vecs[n].we;
      req_addr  = vecs[n].addr;
      req_wdata = vecs[n].wdata;
      #1 check($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(vecs[n].exp_ready));
      @(negedge clk);
    end
    clr_req();
    repeat (5) @(negedge clk);
    check("sb_drain_table", 32'(sb_q.size()), 32'd0);

    // Three back-to-back reads, then a one-cycle reset pulse.
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b0, AW'(k + 1), 8'h00);
      #1 check("flush_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
    end
    clr_req();
    rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_cnt  = 0;
    wait_cyc = 0;
    while (!init_done && wait_cyc < 40) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
      wait_cyc++;
    end
    check("reinit_timeout", 32'(init_done), 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("flush_no_rsp", 32'(rsp_cnt), 32'd0);

    check("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
